// File: rtl/rb_pkg.sv
// Shared types and width helpers for the row-buffer frame scheduler.
package rb_pkg;

    // Scheduler states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRIME     = 3'd1,
        ST_STREAM    = 3'd2,
        ST_ROW_STALL = 3'd3,
        ST_DONE      = 3'd4
    } rb_state_e;

    // Width of the optional performance counters
    localparam int RB_PERF_W = 32;

    // Bits needed to address n locations; never less than one bit
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rb_wrap_counter.sv
// Modulo-N counter with synchronous clear, enable and a wrap flag.
// at_max is high while the count sits at N-1; wrap is high when an
// enabled step takes the count from N-1 back to 0.
module rb_wrap_counter
    import rb_pkg::*;
#(
    parameter int N = 8,
    localparam int W = addr_w(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         at_max,
    output logic         wrap
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear has priority, otherwise step and wrap at N-1
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == W'(N - 1)) ? '0 : cnt_q + W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt    = cnt_q;
    assign at_max = (cnt_q == W'(N - 1));
    assign wrap   = en && at_max;

endmodule

// File: rtl/rb_frame_scheduler.sv
// Row-buffer frame scheduler: walks one frame in raster order, issuing
// fetch/write/read strobes, addresses and the steering select. Reads are
// held off until RB_COUNT rows are primed; STALL_CYCLES idle cycles follow
// each completed row; sink backpressure pauses the stream.
// Optional build macro RBS_PERF_CNT_EN adds beat/stall/backpressure counters.
module rb_frame_scheduler
    import rb_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 256,
    parameter int IMAGE_HEIGHT = 256,
    parameter int KERNEL_SIZE  = 9,
    parameter int RB_COUNT     = KERNEL_SIZE - 1,
    parameter int STALL_CYCLES = 1,
    localparam int EW = addr_w(IMAGE_WIDTH * IMAGE_HEIGHT),
    localparam int WW = addr_w(RB_COUNT * IMAGE_WIDTH),
    localparam int CW = addr_w(IMAGE_WIDTH),
    localparam int RW = addr_w(IMAGE_HEIGHT),
    localparam int SW = addr_w(RB_COUNT),
    localparam int TW = addr_w(STALL_CYCLES + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          ext_ready,
    input  logic          sink_ready,
    output logic          en_E,
    output logic          en_W,
    output logic          en_R,
    output logic [EW-1:0] e_addr,
    output logic [WW-1:0] w_addr,
    output logic [CW-1:0] r_addr,
    output logic [SW-1:0] steer_sel,
    output logic          E_last,
    output logic          W_frame_filled,
    output logic          window_valid,
    output logic          frame_done,
    output logic          busy
`ifdef RBS_PERF_CNT_EN
    ,
    output logic [RB_PERF_W-1:0] beat_cnt,
    output logic [RB_PERF_W-1:0] stall_cnt,
    output logic [RB_PERF_W-1:0] bp_cnt
`endif
);

    rb_state_e state_q, state_d;
    logic [TW-1:0] stall_q, stall_d;
    logic          filled_q, filled_d;

    logic          en_e_q, en_e_d;
    logic          en_w_q, en_w_d;
    logic          en_r_q, en_r_d;
    logic [EW-1:0] e_addr_q, e_addr_d;
    logic [WW-1:0] w_addr_q, w_addr_d;
    logic [CW-1:0] r_addr_q, r_addr_d;
    logic [SW-1:0] steer_q, steer_d;
    logic          e_last_q, e_last_d;
    logic          w_filled_q, w_filled_d;
    logic          wvalid_q, wvalid_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;

    logic          beat;
    logic          clr;
    logic          row_end;
    logic          frame_end;
    logic          prime_end;

    logic [CW-1:0] col_cnt;
    logic [RW-1:0] row_cnt;
    logic [SW-1:0] slot_cnt;
    logic          col_max_unused;
    logic          row_max;
    logic          row_wrap_unused;
    logic          slot_max_unused;
    logic          slot_wrap_unused;

    rb_wrap_counter #(.N(IMAGE_WIDTH)) u_col (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .en     (beat),
        .cnt    (col_cnt),
        .at_max (col_max_unused),
        .wrap   (row_end)
    );

    rb_wrap_counter #(.N(IMAGE_HEIGHT)) u_row (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .en     (row_end),
        .cnt    (row_cnt),
        .at_max (row_max),
        .wrap   (row_wrap_unused)
    );

    rb_wrap_counter #(.N(RB_COUNT)) u_slot (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .en     (row_end),
        .cnt    (slot_cnt),
        .at_max (slot_max_unused),
        .wrap   (slot_wrap_unused)
    );

    // Beat qualification and row/frame boundary decode
    always_comb begin
        beat      = ext_ready && ((state_q == ST_PRIME) ||
                                  (state_q == ST_STREAM && sink_ready));
        clr       = (state_q == ST_IDLE) && start;
        frame_end = row_end && row_max;
        prime_end = (state_q == ST_PRIME) && row_end &&
                    (32'(row_cnt) == RB_COUNT - 1);
    end

    // Next-state and registered-output values
    always_comb begin
        state_d    = state_q;
        stall_d    = stall_q;
        filled_d   = filled_q;
        en_e_d     = 1'b0;
        en_w_d     = 1'b0;
        en_r_d     = 1'b0;
        e_last_d   = 1'b0;
        e_addr_d   = e_addr_q;
        w_addr_d   = w_addr_q;
        r_addr_d   = r_addr_q;
        steer_d    = steer_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_PRIME;
                    stall_d  = '0;
                    filled_d = 1'b0;
                end
            end
            ST_PRIME, ST_STREAM: begin
                if (beat) begin
                    en_e_d   = 1'b1;
                    en_w_d   = 1'b1;
                    e_addr_d = EW'(row_cnt) * EW'(IMAGE_WIDTH) + EW'(col_cnt);
                    w_addr_d = WW'(slot_cnt) * WW'(IMAGE_WIDTH) + WW'(col_cnt);
                    steer_d  = slot_cnt;
                    e_last_d = frame_end;
                    if (state_q == ST_STREAM) begin
                        en_r_d   = 1'b1;
                        r_addr_d = col_cnt;
                    end
                    if (frame_end) begin
                        state_d = ST_DONE;
                    end else if (row_end) begin
                        if (prime_end) begin
                            filled_d = 1'b1;
                        end
                        stall_d = '0;
                        if (STALL_CYCLES > 0) begin
                            state_d = ST_ROW_STALL;
                        end else begin
                            state_d = (prime_end || filled_q) ? ST_STREAM : ST_PRIME;
                        end
                    end
                end
            end
            ST_ROW_STALL: begin
                if (stall_q == TW'(STALL_CYCLES - 1)) begin
                    stall_d = '0;
                    state_d = filled_q ? ST_STREAM : ST_PRIME;
                end else begin
                    stall_d = stall_q + TW'(1);
                end
            end
            ST_DONE: begin
                filled_d = 1'b0;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Status outputs trail the internal state by one register stage
        w_filled_d = filled_q && (state_q != ST_DONE);
        wvalid_d   = en_r_q;
        done_d     = (state_q == ST_DONE);
        busy_d     = (state_q != ST_IDLE);
    end

    // State, control and output registers; everything returns to zero on reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            stall_q    <= '0;
            filled_q   <= 1'b0;
            en_e_q     <= 1'b0;
            en_w_q     <= 1'b0;
            en_r_q     <= 1'b0;
            e_addr_q   <= '0;
            w_addr_q   <= '0;
            r_addr_q   <= '0;
            steer_q    <= '0;
            e_last_q   <= 1'b0;
            w_filled_q <= 1'b0;
            wvalid_q   <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            stall_q    <= stall_d;
            filled_q   <= filled_d;
            en_e_q     <= en_e_d;
            en_w_q     <= en_w_d;
            en_r_q     <= en_r_d;
            e_addr_q   <= e_addr_d;
            w_addr_q   <= w_addr_d;
            r_addr_q   <= r_addr_d;
            steer_q    <= steer_d;
            e_last_q   <= e_last_d;
            w_filled_q <= w_filled_d;
            wvalid_q   <= wvalid_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    assign en_E           = en_e_q;
    assign en_W           = en_w_q;
    assign en_R           = en_r_q;
    assign e_addr         = e_addr_q;
    assign w_addr         = w_addr_q;
    assign r_addr         = r_addr_q;
    assign steer_sel      = steer_q;
    assign E_last         = e_last_q;
    assign W_frame_filled = w_filled_q;
    assign window_valid   = wvalid_q;
    assign frame_done     = done_q;
    assign busy           = busy_q;

`ifdef RBS_PERF_CNT_EN
    logic [RB_PERF_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [RB_PERF_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [RB_PERF_W-1:0] bp_cnt_q, bp_cnt_d;

    function automatic logic [RB_PERF_W-1:0] sat_inc(input logic [RB_PERF_W-1:0] v);
        return (v == '1) ? v : v + RB_PERF_W'(1);
    endfunction

    // Saturating event counters, cleared when a frame starts
    always_comb begin
        beat_cnt_d  = beat ? sat_inc(beat_cnt_q) : beat_cnt_q;
        stall_cnt_d = (state_q == ST_ROW_STALL) ? sat_inc(stall_cnt_q) : stall_cnt_q;
        bp_cnt_d    = (state_q == ST_STREAM && ext_ready && !sink_ready) ?
                      sat_inc(bp_cnt_q) : bp_cnt_q;
        if (clr) begin
            beat_cnt_d  = '0;
            stall_cnt_d = '0;
            bp_cnt_d    = '0;
        end
    end

    // Performance counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_cnt_q  <= '0;
            stall_cnt_q <= '0;
            bp_cnt_q    <= '0;
        end else begin
            beat_cnt_q  <= beat_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            bp_cnt_q    <= bp_cnt_d;
        end
    end

    assign beat_cnt  = beat_cnt_q;
    assign stall_cnt = stall_cnt_q;
    assign bp_cnt    = bp_cnt_q;
`endif

endmodule
